multi_code_counter: RTL and testbench

Parametrised synchronous counter with selectable output encoding: binary, BCD (multi-digit, decimal cascade) or Gray. It supports up/down counting, count enable, parallel load and a one-cycle terminal-count flag. It is the general-purpose successor to the fixed 3-bit BCD/Gray counter and serves as the counting element for display, sequencing and encoder-test logic in the design.

---
 rtl/multi_code_counter_pkg.sv | 27 ++
 rtl/multi_code_counter_bcd_digit_stage.sv | 35 +++
 rtl/multi_code_counter.sv | 87 ++++++++
 tb/tb_multi_code_counter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_code_counter_pkg.sv
// Shared mode encodings and Gray/binary conversion helpers for multi_code_counter.
// Conversions work on a wide fixed type; callers size-cast in and out.
package multi_code_counter_pkg;

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_BCD  = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam int CONV_W = 64;
    typedef logic [CONV_W-1:0] conv_t;

    function automatic conv_t bin_to_gray(input conv_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits leave the lower decoded bits unaffected.
    function automatic conv_t gray_to_bin(input conv_t g);
        conv_t b;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/multi_code_counter_bcd_digit_stage.sv
// Next-state logic for one BCD digit with carry/borrow chaining.
// The digit storage itself is the matching nibble of the top-level count register.
module bcd_digit_stage (
    input  logic [3:0] digit,
    input  logic       up,
    input  logic       step_in,
    input  logic       load,
    input  logic       clear,
    input  logic [3:0] load_digit,
    output logic [3:0] next_digit,
    output logic       step_out
);

    logic at_end;

    assign at_end   = up ? (digit == 4'd9) : (digit == 4'd0);
    // Chained step_out of the last digit marks a full-range wrap.
    assign step_out = step_in & at_end;

    always_comb begin
        next_digit = digit;
        if (clear) begin
            next_digit = 4'd0;
        end else if (load) begin
            next_digit = (load_digit > 4'd9) ? 4'd0 : load_digit;
        end else if (step_in) begin
            if (at_end) begin
                next_digit = up ? 4'd0 : 4'd9;
            end else begin
                next_digit = up ? digit + 4'd1 : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/multi_code_counter.sv
// Up/down counter with binary, multi-digit BCD or Gray output encoding,
// parallel load and a one-cycle terminal-count flag.
module multi_code_counter
    import multi_code_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Up,
    input  logic [1:0]       Mode,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Counter,
    output logic             Flag
);

    localparam int DIGITS = WIDTH / 4;

    logic [WIDTH-1:0] count;
    logic [1:0]       mode_q;
    logic             mode_change;
    logic             count_step;
    logic             bin_wrap;
    logic [WIDTH-1:0] gray_load;
    logic [WIDTH-1:0] bcd_next;
    logic [DIGITS:0]  bcd_step;

    assign mode_change = (Mode != mode_q);
    assign count_step  = Enable & ~Load;
    assign bin_wrap    = Up ? (count == {WIDTH{1'b1}}) : (count == {WIDTH{1'b0}});
    assign gray_load   = WIDTH'(gray_to_bin(CONV_W'(LoadValue)));
    assign bcd_step[0] = count_step;

    for (genvar g = 0; g < DIGITS; g++) begin : g_bcd
        bcd_digit_stage u_stage (
            .digit      (count[4*g +: 4]),
            .up         (Up),
            .step_in    (bcd_step[g]),
            .load       (Load),
            .clear      (~Reset_n | mode_change),
            .load_digit (LoadValue[4*g +: 4]),
            .next_digit (bcd_next[4*g +: 4]),
            .step_out   (bcd_step[g+1])
        );
    end

    // Binary and Gray share the binary count; BCD rewrites the same bits digit-wise.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            count  <= '0;
            Flag   <= 1'b0;
            mode_q <= Mode;
        end else if (mode_change) begin
            count  <= '0;
            Flag   <= 1'b0;
            mode_q <= Mode;
        end else begin
            Flag <= 1'b0;
            case (mode_q)
                MODE_BIN, MODE_GRAY: begin
                    if (Load) begin
                        count <= (mode_q == MODE_GRAY) ? gray_load : LoadValue;
                    end else if (Enable) begin
                        count <= Up ? count + WIDTH'(1) : count - WIDTH'(1);
                        Flag  <= bin_wrap;
                    end
                end
                MODE_BCD: begin
                    count <= bcd_next;
                    Flag  <= bcd_step[DIGITS];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mode_q)
            MODE_GRAY: Counter = WIDTH'(bin_to_gray(CONV_W'(count)));
            MODE_RSVD: Counter = '0;
            default:   Counter = count;
        endcase
    end

endmodule

// File: tb/tb_multi_code_counter.sv
// Directed and randomized bench for multi_code_counter (WIDTH = 8) against
// a numeric-value reference model.
module tb_multi_code_counter;

    logic       Clock;
    logic       Reset_n;
    logic       Enable;
    logic       Up;
    logic [1:0] Mode;
    logic       Load;
    logic [7:0] LoadValue;
    logic [7:0] Counter;
    logic       Flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: numeric count value, current mode and flag
    int         m_val  = 0;
    logic [1:0] m_mode = 2'b00;
    logic       m_flag = 1'b0;

    multi_code_counter #(.WIDTH(8)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Enable    (Enable),
        .Up        (Up),
        .Mode      (Mode),
        .Load      (Load),
        .LoadValue (LoadValue),
        .Counter   (Counter),
        .Flag      (Flag)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int modulus(input logic [1:0] md);
        return (md == 2'b01) ? 100 : 256;
    endfunction

    function automatic int load_value_of(input logic [1:0] md, input logic [7:0] lv);
        int d0, d1;
        logic [7:0] b;
        logic acc;
        case (md)
            2'b01: begin
                d0 = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
                d1 = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
                return d1 * 10 + d0;
            end
            2'b10: begin
                acc = 1'b0;
                for (int i = 7; i >= 0; i--) begin
                    acc  = acc ^ lv[i];
                    b[i] = acc;
                end
                return int'(b);
            end
            default: return int'(lv);
        endcase
    endfunction

    function automatic logic [7:0] expected_counter();
        logic [7:0] v;
        v = 8'(m_val);
        case (m_mode)
            2'b01:   return 8'(((m_val / 10) << 4) | (m_val % 10));
            2'b10:   return v ^ (v >> 1);
            2'b11:   return 8'h00;
            default: return v;
        endcase
    endfunction

    task automatic model_update();
        int mx;
        mx = modulus(m_mode) - 1;
        if (!Reset_n || Mode != m_mode) begin
            m_val  = 0;
            m_flag = 1'b0;
            m_mode = Mode;
        end else if (m_mode == 2'b11) begin
            m_flag = 1'b0;
        end else if (Load) begin
            m_val  = load_value_of(m_mode, LoadValue);
            m_flag = 1'b0;
        end else if (Enable) begin
            if (Up) begin
                m_flag = (m_val == mx);
                m_val  = (m_val == mx) ? 0 : m_val + 1;
            end else begin
                m_flag = (m_val == 0);
                m_val  = (m_val == 0) ? mx : m_val - 1;
            end
        end else begin
            m_flag = 1'b0;
        end
    endtask

    task automatic check();
        logic [7:0] exp_c;
        exp_c = expected_counter();
        checks++;
        assert (Counter === exp_c) else begin
            errors++;
            $error("FAIL counter cyc=%0d mode=%0d: got %h expected %h", cyc, m_mode, Counter, exp_c);
        end
        checks++;
        assert (Flag === m_flag) else begin
            errors++;
            $error("FAIL flag cyc=%0d mode=%0d: got %b expected %b", cyc, m_mode, Flag, m_flag);
        end
    endtask

    task automatic step(input logic rstn, input logic [1:0] md, input logic ld,
                        input logic [7:0] lv, input logic en, input logic up);
        Reset_n   = rstn;
        Mode      = md;
        Load      = ld;
        LoadValue = lv;
        Enable    = en;
        Up        = up;
        model_update();
        @(posedge Clock);
        #1;
        cyc++;
        check();
    endtask

    logic [7:0] edge_vals [8] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h99, 8'h98, 8'h80, 8'hA5};
    logic [1:0] r_mode;
    logic       r_up;
    logic [7:0] r_lv;

    initial begin
        Reset_n = 1'b0; Mode = 2'b00; Load = 1'b0; LoadValue = 8'h00; Enable = 1'b0; Up = 1'b1;
        @(negedge Clock);

        // Reset with Enable high
        step(0, 2'b00, 0, 8'h00, 1, 1);
        step(0, 2'b00, 0, 8'h00, 1, 1);

        // Binary wrap up then down
        step(1, 2'b00, 1, 8'hFE, 0, 1);
        step(1, 2'b00, 0, 8'h00, 1, 1);
        step(1, 2'b00, 0, 8'h00, 1, 1);
        step(1, 2'b00, 0, 8'h00, 1, 1);
        step(1, 2'b00, 0, 8'h00, 1, 0);
        step(1, 2'b00, 0, 8'h00, 1, 0);
        step(1, 2'b00, 0, 8'h00, 0, 0);

        // BCD wrap, borrow wrap and invalid-digit load
        step(1, 2'b01, 0, 8'h00, 0, 1);
        step(1, 2'b01, 1, 8'h98, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 8'h00, 1, 1);
        step(1, 2'b01, 1, 8'h00, 0, 0);
        step(1, 2'b01, 0, 8'h00, 1, 0);
        step(1, 2'b01, 0, 8'h00, 1, 0);
        step(1, 2'b01, 1, 8'hA5, 0, 0);
        step(1, 2'b01, 1, 8'h9A, 0, 0);

        // Gray sequence from reset and wrap after Gray load
        step(0, 2'b10, 0, 8'h00, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 2'b10, 0, 8'h00, 1, 1);
        step(1, 2'b10, 1, 8'h80, 0, 1);
        step(1, 2'b10, 0, 8'h00, 1, 1);
        step(1, 2'b10, 0, 8'h00, 1, 0);

        // Mode change mid-count overrides Enable
        step(1, 2'b00, 0, 8'h00, 0, 1);
        step(1, 2'b00, 1, 8'h37, 0, 1);
        step(1, 2'b01, 0, 8'h00, 1, 1);
        step(1, 2'b01, 0, 8'h00, 1, 1);
        step(1, 2'b01, 0, 8'h00, 1, 1);

        // Load beats Enable; reset mid-count; reserved mode holds at zero
        step(1, 2'b00, 0, 8'h00, 0, 1);
        step(1, 2'b00, 1, 8'h42, 1, 1);
        step(1, 2'b00, 1, 8'h50, 0, 1);
        step(1, 2'b00, 0, 8'h00, 1, 1);
        step(0, 2'b00, 0, 8'h00, 1, 1);
        step(0, 2'b00, 0, 8'h00, 1, 1);
        step(1, 2'b00, 0, 8'h00, 1, 1);
        step(1, 2'b11, 0, 8'h00, 1, 1);
        step(1, 2'b11, 1, 8'h55, 1, 1);
        step(1, 2'b11, 0, 8'h00, 1, 0);

        // Randomized traffic biased toward edge values
        r_mode = 2'b00;
        r_up   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) r_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  r_up   = ~r_up;
            r_lv = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 7)] : 8'($urandom);
            step(($urandom_range(0, 59) != 0), r_mode, ($urandom_range(0, 11) == 0), r_lv,
                 ($urandom_range(0, 3) != 0), r_up);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
